ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of each core, directly downstream of the ID/EX pipeline register; consumes its registered operands and control.
- Performs operand forwarding, ALU operations, branch resolution and an iterative 32-cycle multiply/divide.
- Holds the EX/MEM pipeline register and drives ex_busy, which the hazard unit ORs into pipeline_stall.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations of the mul/div engine; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_stall  input  1  1 = MEM stage stalled: hold the EX/MEM register and freeze the mul/div engine
- ex_pc_plus_4_in, ex_read_data1_in, ex_read_data2_in, ex_immediate_in  input  32 each  from ID/EX
- ex_rs1_addr_in, ex_rs2_addr_in, ex_rd_addr_in  input  5 each  from ID/EX
- ex_mem_read_in, ex_mem_write_in, ex_reg_write_in, ex_MemToReg_in, ex_ALUSrc_in, ex_Branch_in  input  1 each  control from ID/EX
- ex_ALUCtrl_in  input  4  operation code
- wb_rd_addr  input  5  WB destination register
- wb_reg_write  input  1  WB write enable
- wb_data  input  32  WB write-back value
- ex_busy  output  1  mul/div in progress; upstream must hold
- ex_branch_taken  output  1  redirect IF and flush IF/ID and ID/EX (combinational)
- ex_branch_target  output  32  redirect address (combinational)
- mem_alu_result_out, mem_store_data_out  output  32 each  registered EX/MEM outputs
- mem_rd_addr_out  output  5  registered
- mem_mem_read_out, mem_mem_write_out, mem_reg_write_out, mem_MemToReg_out  output  1 each  registered

Behaviour:
- Reset (rst_n=0, asynchronous): all EX/MEM outputs 0; mul/div FSM to IDLE; iteration counter 0. Reset mid-operation aborts the operation and produces no result.
- Forwarding, per source operand:
  - Use the EX/MEM result if mem_reg_write_out && mem_rd_addr_out!=0 && it matches the source register.
  - Otherwise use wb_data if wb_reg_write && wb_rd_addr!=0 && it matches.
  - Otherwise use the ID/EX read data.
  - EX/MEM has priority over WB. Register 0 is never forwarded.
- Operand B = ALUSrc ? immediate : forwarded rs2. Store data is always forwarded rs2.
- ALUCtrl codes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = B[4:0])
  - 8 SLT (signed); 9 SLTU
  - 10 MUL (low 32 bits); 11 MULHU (high 32 bits, unsigned); 12 DIVU; 13 REMU
  - 14 PASS_B; 15 result 0
- Branch: ex_branch_taken = Branch && (A−B)==0. ex_branch_target = pc_plus_4 − 4 + immediate. Both are forced to 0 while ex_busy.
- Mul/div FSM, codes 10–13 only, with states IDLE, BUSY, DONE:
  - IDLE: an MD op is present → ex_busy=1 combinationally in the same cycle; latch the forwarded operands and op; go to BUSY with count=0.
  - BUSY: ex_busy=1; one shift-add / restoring-divide step per cycle unless mem_stall. After MD_CYCLES steps go to DONE.
  - DONE: ex_busy=0; the result drives the EX/MEM input; at the edge, if !mem_stall, EX/MEM captures it and the FSM returns to IDLE. The FSM does not retrigger on the same op in DONE.
  - Total: ex_busy is high for MD_CYCLES+1 cycles, and the result appears at the EX/MEM outputs MD_CYCLES+2 edges after the op enters EX.
- Divide by zero: DIVU = 0xFFFFFFFF; REMU = dividend. No trap.
- EX/MEM register update rules:
  - mem_stall=1: hold all outputs (this takes priority).
  - ex_busy=1: load a bubble (all control outputs 0, data/rd 0).
  - Otherwise: load the computed values.
- All arithmetic is modulo 2^32; no overflow flags.

Test Plan:
- Reset mid-BUSY: DIVU in progress, rst_n pulsed low at iteration 10 → outputs 0 immediately; FSM IDLE; ex_busy=0 after release; no stale result later.
- Forwarding priority: EX/MEM holds rd=5 value 0x11, WB rd=5 value 0x22, current ADD x5+x0 → result 0x11. Then rd=0 writes with 0x99 → operand uses register-file data.
- MUL/MULHU: 0xFFFFFFFF × 0x2 → MUL 0xFFFFFFFE, MULHU 0x1. ex_busy high exactly 33 cycles; a bubble enters EX/MEM each busy cycle.
- DIVU/REMU: 100/7 → 14, remainder 2. 0x1234/0 → DIVU 0xFFFFFFFF, REMU 0x1234.
- Branch: Branch=1, A=B=7, pc_plus_4=0x104, imm=0x20 → taken=1, target 0x120. With A≠B → taken=0.
- mem_stall during DONE for 3 cycles → EX/MEM holds its prior values and the FSM stays in DONE; the result is captured on the first edge with mem_stall=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage sitting between the ID/EX and EX/MEM pipeline registers.
//
// Purpose:
//   - Forwards operands from EX/MEM (highest priority) or WB into the ALU.
//   - Evaluates single-cycle ALU operations.
//   - Resolves branches combinationally.
//   - Runs an iterative multiply/divide engine (MUL, MULHU, DIVU, REMU) over MD_CYCLES steps.
//   - Owns the EX/MEM pipeline register.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   mem_stall                  MEM stalled: hold EX/MEM and freeze the mul/div engine
//   ex_*_in                    registered operands and control from ID/EX
//   wb_rd_addr/wb_reg_write/wb_data
//                              write-back port, used as a forwarding source
//   ex_busy                    mul/div in progress; upstream must hold ID/EX
//   ex_branch_taken/target     combinational redirect for IF; both are 0 while busy
//   mem_*_out                  registered EX/MEM outputs
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] ex_pc_plus_4_in,
    input  logic [XLEN-1:0] ex_read_data1_in,
    input  logic [XLEN-1:0] ex_read_data2_in,
    input  logic [XLEN-1:0] ex_immediate_in,
    input  logic [4:0]      ex_rs1_addr_in,
    input  logic [4:0]      ex_rs2_addr_in,
    input  logic [4:0]      ex_rd_addr_in,
    input  logic            ex_mem_read_in,
    input  logic            ex_mem_write_in,
    input  logic            ex_reg_write_in,
    input  logic            ex_MemToReg_in,
    input  logic            ex_ALUSrc_in,
    input  logic            ex_Branch_in,
    input  logic [3:0]      ex_ALUCtrl_in,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_busy,
    output logic            ex_branch_taken,
    output logic [XLEN-1:0] ex_branch_target,
    output logic [XLEN-1:0] mem_alu_result_out,
    output logic [XLEN-1:0] mem_store_data_out,
    output logic [4:0]      mem_rd_addr_out,
    output logic            mem_mem_read_out,
    output logic            mem_mem_write_out,
    output logic            mem_reg_write_out,
    output logic            mem_MemToReg_out
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_MULHU = 4'd11;
    localparam logic [3:0] ALU_DIVU  = 4'd12;
    localparam logic [3:0] ALU_REMU  = 4'd13;
    localparam logic [3:0] ALU_PASSB = 4'd14;

    // Bits resolved per engine step, so that any MD_CYCLES >= 1 still covers all XLEN bits.
    localparam int BPS = (XLEN + MD_CYCLES - 1) / MD_CYCLES;
    localparam int CW  = $clog2(MD_CYCLES + 1);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t       md_state, md_state_next;
    logic [CW-1:0]   md_count;
    logic [XLEN:0]   md_hi;
    logic [XLEN-1:0] md_lo;
    logic [XLEN-1:0] md_b;
    logic [3:0]      md_op;
    logic [XLEN:0]   step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN:0]   md_shifted, md_diff, md_sum;
    logic [XLEN-1:0] md_result;
    logic            md_is_div;
    logic            is_md;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_out, ex_result;
    logic            hit_mem_a, hit_wb_a, hit_mem_b, hit_wb_b;

    // EX/MEM wins over WB; x0 is never forwarded from either source.
    assign hit_mem_a = mem_reg_write_out && (mem_rd_addr_out != 5'd0) && (mem_rd_addr_out == ex_rs1_addr_in);
    assign hit_wb_a  = wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs1_addr_in);
    assign hit_mem_b = mem_reg_write_out && (mem_rd_addr_out != 5'd0) && (mem_rd_addr_out == ex_rs2_addr_in);
    assign hit_wb_b  = wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs2_addr_in);

    assign op_a  = hit_mem_a ? mem_alu_result_out : (hit_wb_a ? wb_data : ex_read_data1_in);
    assign fwd_b = hit_mem_b ? mem_alu_result_out : (hit_wb_b ? wb_data : ex_read_data2_in);
    assign op_b  = ex_ALUSrc_in ? ex_immediate_in : fwd_b;

    assign is_md     = (ex_ALUCtrl_in >= ALU_MUL) && (ex_ALUCtrl_in <= ALU_REMU);
    assign md_is_div = (md_op == ALU_DIVU) || (md_op == ALU_REMU);

    // Single-cycle ALU. Mul/div codes produce 0 here; their result comes from the engine.
    always_comb begin
        alu_out = '0;
        case (ex_ALUCtrl_in)
            ALU_ADD:   alu_out = op_a + op_b;
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_OR:    alu_out = op_a | op_b;
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SLL:   alu_out = op_a << op_b[SHW-1:0];
            ALU_SRL:   alu_out = op_a >> op_b[SHW-1:0];
            ALU_SRA:   alu_out = $signed(op_a) >>> op_b[SHW-1:0];
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_out = op_b;
            default:   alu_out = '0;
        endcase
    end

    // One engine step. Multiply is shift-add with the multiplier in md_lo and the
    // partial product growing in md_hi. Divide is restoring division with the
    // remainder in md_hi and the quotient shifting into md_lo. A zero divisor
    // naturally yields an all-ones quotient and remainder = dividend.
    always_comb begin
        step_hi    = md_hi;
        step_lo    = md_lo;
        md_shifted = '0;
        md_diff    = '0;
        md_sum     = '0;
        for (int j = 0; j < BPS; j++) begin
            if (int'(md_count) * BPS + j < XLEN) begin
                if (md_is_div) begin
                    md_shifted = {step_hi[XLEN-1:0], step_lo[XLEN-1]};
                    md_diff    = md_shifted - {1'b0, md_b};
                    if (!md_diff[XLEN]) begin
                        step_hi = md_diff;
                        step_lo = {step_lo[XLEN-2:0], 1'b1};
                    end else begin
                        step_hi = md_shifted;
                        step_lo = {step_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    md_sum  = {1'b0, step_hi[XLEN-1:0]} + (step_lo[0] ? {1'b0, md_b} : '0);
                    step_hi = {1'b0, md_sum[XLEN:1]};
                    step_lo = {md_sum[0], step_lo[XLEN-1:1]};
                end
            end
        end
    end

    always_comb begin
        md_result = '0;
        case (md_op)
            ALU_MUL:   md_result = md_lo;
            ALU_MULHU: md_result = md_hi[XLEN-1:0];
            ALU_DIVU:  md_result = md_lo;
            ALU_REMU:  md_result = md_hi[XLEN-1:0];
            default:   md_result = '0;
        endcase
    end

    // Mul/div next state and busy. Busy is raised in IDLE as soon as an MD op is
    // present, and dropped in DONE so the result can flow into EX/MEM.
    always_comb begin
        md_state_next = md_state;
        ex_busy       = 1'b0;
        case (md_state)
            MD_IDLE: begin
                if (is_md) begin
                    ex_busy = 1'b1;
                    if (!mem_stall) md_state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                ex_busy = 1'b1;
                if (!mem_stall && md_count == CW'(MD_CYCLES - 1)) md_state_next = MD_DONE;
            end
            MD_DONE: begin
                if (!mem_stall) md_state_next = MD_IDLE;
            end
            default: md_state_next = MD_IDLE;
        endcase
    end

    // Mul/div state and datapath registers; everything freezes while MEM stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_count <= '0;
            md_hi    <= '0;
            md_lo    <= '0;
            md_b     <= '0;
            md_op    <= '0;
        end else begin
            md_state <= md_state_next;
            if (!mem_stall) begin
                if (md_state == MD_IDLE && is_md) begin
                    md_count <= '0;
                    md_op    <= ex_ALUCtrl_in;
                    md_hi    <= '0;
                    md_lo    <= op_a;
                    md_b     <= op_b;
                end else if (md_state == MD_BUSY) begin
                    md_count <= md_count + 1'b1;
                    md_hi    <= step_hi;
                    md_lo    <= step_lo;
                end
            end
        end
    end

    assign ex_result = (md_state == MD_DONE) ? md_result : alu_out;

    assign ex_branch_taken  = ex_Branch_in && ((op_a - op_b) == '0) && !ex_busy;
    assign ex_branch_target = ex_busy ? '0 : (ex_pc_plus_4_in - XLEN'(4) + ex_immediate_in);

    // EX/MEM register: stall holds, busy inserts a bubble, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_alu_result_out <= '0;
            mem_store_data_out <= '0;
            mem_rd_addr_out    <= '0;
            mem_mem_read_out   <= 1'b0;
            mem_mem_write_out  <= 1'b0;
            mem_reg_write_out  <= 1'b0;
            mem_MemToReg_out   <= 1'b0;
        end else if (!mem_stall) begin
            if (ex_busy) begin
                mem_alu_result_out <= '0;
                mem_store_data_out <= '0;
                mem_rd_addr_out    <= '0;
                mem_mem_read_out   <= 1'b0;
                mem_mem_write_out  <= 1'b0;
                mem_reg_write_out  <= 1'b0;
                mem_MemToReg_out   <= 1'b0;
            end else begin
                mem_alu_result_out <= ex_result;
                mem_store_data_out <= fwd_b;
                mem_rd_addr_out    <= ex_rd_addr_in;
                mem_mem_read_out   <= ex_mem_read_in;
                mem_mem_write_out  <= ex_mem_write_in;
                mem_reg_write_out  <= ex_reg_write_in;
                mem_MemToReg_out   <= ex_MemToReg_in;
            end
        end
    end

endmodule
